// File: rtl/shift_rs_ctrl.sv
// shift_rs_ctrl: two-entry reservation station in front of the shifter unit.
//
// Purpose
//   Holds up to two dispatched shift operations, snoops the common data bus
//   for missing source operands, issues the oldest ready entry to the shifter
//   (at most one per cycle) and re-tags the shifter's broadcast one cycle
//   after issue with the issuing entry's CDB tag.
//
// Ports
//   clk_i, reset_i (async, active-low), flush_i (sync squash)
//   disp_*       dispatch request, operation, source tags and values
//   full_o       both entries busy
//   cdb_i        global CDB, snooped for operand wake-up
//   oper_o, rs1_val_o, rs2_val_o, ready_o   issue to shifter
//   shifter_cdb_i   raw shifter broadcast term
//   cdb_term_o      shifter broadcast re-tagged with the issuing entry's tag
//
// Build option
//   SHIFT_RS_CDB_FWD_EN : a waiting entry whose last pending operand appears
//   on cdb_i may issue in that same cycle, with cdb_i.val forwarded onto the
//   operand output. Undefined by default (entry issues one cycle later).

package shift_rs_pkg;
  typedef logic [31:0] word32_t;

  typedef enum logic [2:0] {
    NO_VAL  = 3'd0,
    ALU_1   = 3'd1,
    ALU_2   = 3'd2,
    MUL_1   = 3'd3,
    MUL_2   = 3'd4,
    SHIFT_1 = 3'd5,
    SHIFT_2 = 3'd6,
    LSU_1   = 3'd7
  } rs_tag_t;

  typedef enum logic [1:0] {
    SLLI = 2'd0,
    SRLI = 2'd1,
    SRAI = 2'd2,
    SRAR = 2'd3
  } shift_op_t;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;
endpackage

// Entry states (index 0 = entry A, index 1 = entry B)
//   state | meaning
//   FREE  | busy=0, slot available for dispatch
//   WAIT  | busy=1, at least one source tag still != NO_VAL
//   RDY   | busy=1, both operands present, candidate for issue
module shift_rs_ctrl
  import shift_rs_pkg::*;
#(
  parameter rs_tag_t TAG_A = SHIFT_1,
  parameter rs_tag_t TAG_B = SHIFT_2
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      flush_i,
  input  logic      disp_valid_i,
  input  shift_op_t disp_op_i,
  input  rs_tag_t   disp_rs1_tag_i,
  input  rs_tag_t   disp_rs2_tag_i,
  input  word32_t   disp_rs1_val_i,
  input  word32_t   disp_rs2_val_i,
  output logic      full_o,
  input  cdb_t      cdb_i,
  output shift_op_t oper_o,
  output word32_t   rs1_val_o,
  output word32_t   rs2_val_o,
  output logic      ready_o,
  input  cdb_t      shifter_cdb_i,
  output cdb_t      cdb_term_o
);

  logic [1:0] busy_q;
  shift_op_t  op_q [2];
  rs_tag_t    q1_q [2];
  rs_tag_t    q2_q [2];
  word32_t    v1_q [2];
  word32_t    v2_q [2];
  // 1 when entry B was dispatched before entry A
  logic       older_b_q;
  rs_tag_t    tag_pipe_q;

  logic       cdb_hit;
  logic [1:0] hit1, hit2;
  logic [1:0] avail1, avail2;
  logic [1:0] elig;
  word32_t    opnd1 [2];
  word32_t    opnd2 [2];
  logic       sel_b;
  logic       issue;
  logic       disp_en;
  logic       disp_b;
  logic       disp_hit1, disp_hit2;

  assign cdb_hit = (cdb_i.tag != NO_VAL);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit1[i] = cdb_hit && (q1_q[i] == cdb_i.tag);
      hit2[i] = cdb_hit && (q2_q[i] == cdb_i.tag);
`ifdef SHIFT_RS_CDB_FWD_EN
      avail1[i] = (q1_q[i] == NO_VAL) || hit1[i];
      avail2[i] = (q2_q[i] == NO_VAL) || hit2[i];
      opnd1[i]  = (q1_q[i] == NO_VAL) ? v1_q[i] : cdb_i.val;
      opnd2[i]  = (q2_q[i] == NO_VAL) ? v2_q[i] : cdb_i.val;
`else
      avail1[i] = (q1_q[i] == NO_VAL);
      avail2[i] = (q2_q[i] == NO_VAL);
      opnd1[i]  = v1_q[i];
      opnd2[i]  = v2_q[i];
`endif
      elig[i] = busy_q[i] && avail1[i] && avail2[i];
    end
  end

  // B wins only if it is eligible and either A is not, or B is older
  assign sel_b   = elig[1] && (!elig[0] || older_b_q);
  assign issue   = (|elig) && !flush_i;

  assign ready_o   = issue;
  assign oper_o    = sel_b ? op_q[1]  : op_q[0];
  assign rs1_val_o = sel_b ? opnd1[1] : opnd1[0];
  assign rs2_val_o = sel_b ? opnd2[1] : opnd2[0];

  // Full is taken from registered busy bits only, so an entry freed by this
  // cycle's issue cannot be re-filled until the following cycle.
  assign full_o    = &busy_q;
  assign disp_en   = disp_valid_i && !full_o && !flush_i;
  assign disp_b    = busy_q[0];
  assign disp_hit1 = cdb_hit && (disp_rs1_tag_i == cdb_i.tag);
  assign disp_hit2 = cdb_hit && (disp_rs2_tag_i == cdb_i.tag);

  assign cdb_term_o.tag = (shifter_cdb_i.tag != NO_VAL) ? tag_pipe_q : NO_VAL;
  assign cdb_term_o.val = shifter_cdb_i.val;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_q     <= '0;
      older_b_q  <= 1'b0;
      tag_pipe_q <= NO_VAL;
      for (int i = 0; i < 2; i++) begin
        op_q[i] <= SLLI;
        q1_q[i] <= NO_VAL;
        q2_q[i] <= NO_VAL;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
      end
    end else if (flush_i) begin
      busy_q     <= '0;
      tag_pipe_q <= NO_VAL;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busy_q[i] && hit1[i]) begin
          q1_q[i] <= NO_VAL;
          v1_q[i] <= cdb_i.val;
        end
        if (busy_q[i] && hit2[i]) begin
          q2_q[i] <= NO_VAL;
          v2_q[i] <= cdb_i.val;
        end
      end

      if (issue) begin
        busy_q[sel_b] <= 1'b0;
      end

      // Dispatch target is always a free entry, never the one issuing now
      if (disp_en) begin
        busy_q[disp_b] <= 1'b1;
        op_q[disp_b]   <= disp_op_i;
        q1_q[disp_b]   <= disp_hit1 ? NO_VAL : disp_rs1_tag_i;
        v1_q[disp_b]   <= disp_hit1 ? cdb_i.val : disp_rs1_val_i;
        q2_q[disp_b]   <= disp_hit2 ? NO_VAL : disp_rs2_tag_i;
        v2_q[disp_b]   <= disp_hit2 ? cdb_i.val : disp_rs2_val_i;
        // The other entry, if busy, is now the older one
        older_b_q      <= ~disp_b;
      end

      tag_pipe_q <= issue ? (sel_b ? TAG_B : TAG_A) : NO_VAL;
    end
  end

endmodule

// File: tb/tb_shift_rs_ctrl.sv
module tb_shift_rs_ctrl;
  import shift_rs_pkg::*;

`ifdef SHIFT_RS_CDB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic      clk_i;
  logic      reset_i;
  logic      flush_i;
  logic      disp_valid_i;
  shift_op_t disp_op_i;
  rs_tag_t   disp_rs1_tag_i, disp_rs2_tag_i;
  word32_t   disp_rs1_val_i, disp_rs2_val_i;
  logic      full_o;
  cdb_t      cdb_i;
  shift_op_t oper_o;
  word32_t   rs1_val_o, rs2_val_o;
  logic      ready_o;
  cdb_t      shifter_cdb_i;
  cdb_t      cdb_term_o;

  shift_rs_ctrl #(.TAG_A(SHIFT_1), .TAG_B(SHIFT_2)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .disp_valid_i   (disp_valid_i),
    .disp_op_i      (disp_op_i),
    .disp_rs1_tag_i (disp_rs1_tag_i),
    .disp_rs2_tag_i (disp_rs2_tag_i),
    .disp_rs1_val_i (disp_rs1_val_i),
    .disp_rs2_val_i (disp_rs2_val_i),
    .full_o         (full_o),
    .cdb_i          (cdb_i),
    .oper_o         (oper_o),
    .rs1_val_o      (rs1_val_o),
    .rs2_val_o      (rs2_val_o),
    .ready_o        (ready_o),
    .shifter_cdb_i  (shifter_cdb_i),
    .cdb_term_o     (cdb_term_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic      s_full, s_ready;
  shift_op_t s_op;
  word32_t   s_rs1, s_rs2;
  cdb_t      s_term;

  typedef struct packed {
    logic      flush;
    logic      dv;
    shift_op_t op;
    rs_tag_t   t1;
    word32_t   v1;
    rs_tag_t   t2;
    word32_t   v2;
    rs_tag_t   ct;
    word32_t   cv;
    logic      e_full;
    logic      e_rdy;
    shift_op_t e_op;
    word32_t   e1;
    word32_t   e2;
    rs_tag_t   e_tt;
    word32_t   e_tv;
  } vec_t;

  vec_t tbl [13];

  function automatic word32_t do_shift(input shift_op_t op, input word32_t a, input word32_t b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      SLLI:    return a << sh;
      SRLI:    return a >> sh;
      default: return word32_t'($signed(a) >>> sh);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    flush_i        = 1'b0;
    disp_valid_i   = 1'b0;
    disp_op_i      = SLLI;
    disp_rs1_tag_i = NO_VAL;
    disp_rs2_tag_i = NO_VAL;
    disp_rs1_val_i = '0;
    disp_rs2_val_i = '0;
    cdb_i          = '0;
  endtask

  task automatic set_disp(input shift_op_t op, input rs_tag_t t1, input word32_t v1,
                          input rs_tag_t t2, input word32_t v2);
    disp_valid_i   = 1'b1;
    disp_op_i      = op;
    disp_rs1_tag_i = t1;
    disp_rs1_val_i = v1;
    disp_rs2_tag_i = t2;
    disp_rs2_val_i = v2;
  endtask

  task automatic set_cdb(input rs_tag_t t, input word32_t v);
    cdb_i.tag = t;
    cdb_i.val = v;
  endtask

  // Samples outputs mid-cycle, crosses the edge, then plays a 1-cycle
  // shifter: whatever issued this cycle is broadcast in the next one.
  task automatic step();
    @(negedge clk_i);
    s_full  = full_o;
    s_ready = ready_o;
    s_op    = oper_o;
    s_rs1   = rs1_val_o;
    s_rs2   = rs2_val_o;
    s_term  = cdb_term_o;
    @(posedge clk_i);
    #1;
    if (s_ready) begin
      shifter_cdb_i.tag = SHIFT_1;
      shifter_cdb_i.val = do_shift(s_op, s_rs1, s_rs2);
    end else begin
      shifter_cdb_i = '0;
    end
    clr();
  endtask

  task automatic chk_out(input string nm, input logic e_full, input logic e_rdy,
                         input shift_op_t e_op, input word32_t e1, input word32_t e2,
                         input rs_tag_t e_tt, input word32_t e_tv);
    chk({nm, ".full"}, 32'(s_full), 32'(e_full));
    chk({nm, ".ready"}, 32'(s_ready), 32'(e_rdy));
    if (e_rdy) begin
      chk({nm, ".oper"}, 32'(s_op), 32'(e_op));
      chk({nm, ".rs1"}, s_rs1, e1);
      chk({nm, ".rs2"}, s_rs2, e2);
    end
    chk({nm, ".term_tag"}, 32'(s_term.tag), 32'(e_tt));
    chk({nm, ".term_val"}, s_term.val, e_tv);
  endtask

  // Reference model state: entries with dispatch sequence numbers for age
  logic      m_busy [2];
  int        m_seq  [2];
  shift_op_t m_op   [2];
  rs_tag_t   m_q1   [2], m_q2 [2];
  word32_t   m_v1   [2], m_v2 [2];
  logic      m_prev_iss;
  rs_tag_t   m_prev_tag;
  word32_t   m_prev_res;
  int        seq_cnt;
  rs_tag_t   dtags [5];
  rs_tag_t   ctags [5];

  initial begin
    clr();
    reset_i       = 1'b0;
    shifter_cdb_i.tag = SHIFT_1;
    shifter_cdb_i.val = 32'h0000_1234;
    #3;
    chk("reset.full", 32'(full_o), 32'd0);
    chk("reset.ready", 32'(ready_o), 32'd0);
    chk("reset.term_tag", 32'(cdb_term_o.tag), 32'(NO_VAL));
    repeat (2) @(posedge clk_i);
    #1;
    shifter_cdb_i = '0;
    reset_i = 1'b1;

    //        flush dv   op    t1      v1            t2      v2   ct      cv      full rdy e_op  e1            e2   e_tt     e_tv
    tbl[0]  = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,NO_VAL,32'h0,  1'b0,1'b0,SLLI,32'h0,        32'd0,NO_VAL, 32'h0};
    tbl[1]  = '{1'b0,1'b1,SLLI,NO_VAL,32'h1,        NO_VAL,32'd4,NO_VAL,32'h0,  1'b0,1'b0,SLLI,32'h0,        32'd0,NO_VAL, 32'h0};
    tbl[2]  = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,NO_VAL,32'h0,  1'b0,1'b1,SLLI,32'h1,        32'd4,NO_VAL, 32'h0};
    tbl[3]  = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,NO_VAL,32'h0,  1'b0,1'b0,SLLI,32'h0,        32'd0,SHIFT_1,32'h10};
    tbl[4]  = '{1'b0,1'b1,SRLI,MUL_1, 32'hDEAD,     NO_VAL,32'd4,MUL_1, 32'hFF, 1'b0,1'b0,SLLI,32'h0,        32'd0,NO_VAL, 32'h0};
    tbl[5]  = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,NO_VAL,32'h0,  1'b0,1'b1,SRLI,32'hFF,       32'd4,NO_VAL, 32'h0};
    tbl[6]  = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,NO_VAL,32'h0,  1'b0,1'b0,SLLI,32'h0,        32'd0,SHIFT_1,32'hF};
    tbl[7]  = '{1'b0,1'b1,SLLI,ALU_1, 32'h0,        NO_VAL,32'd2,NO_VAL,32'h0,  1'b0,1'b0,SLLI,32'h0,        32'd0,NO_VAL, 32'h0};
    tbl[8]  = '{1'b0,1'b1,SRAI,NO_VAL,32'h8000_0000,NO_VAL,32'd4,NO_VAL,32'h0,  1'b0,1'b0,SLLI,32'h0,        32'd0,NO_VAL, 32'h0};
    tbl[9]  = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,NO_VAL,32'h0,  1'b1,1'b1,SRAI,32'h8000_0000,32'd4,NO_VAL, 32'h0};
    tbl[10] = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,NO_VAL,32'h0,  1'b0,1'b0,SLLI,32'h0,        32'd0,SHIFT_2,32'hF800_0000};
    tbl[11] = '{1'b1,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,ALU_1, 32'h5,  1'b0,1'b0,SLLI,32'h0,        32'd0,NO_VAL, 32'h0};
    tbl[12] = '{1'b0,1'b0,SLLI,NO_VAL,32'h0,        NO_VAL,32'd0,ALU_1, 32'h5,  1'b0,1'b0,SLLI,32'h0,        32'd0,NO_VAL, 32'h0};

    for (int i = 0; i < 13; i++) begin
      flush_i        = tbl[i].flush;
      disp_valid_i   = tbl[i].dv;
      disp_op_i      = tbl[i].op;
      disp_rs1_tag_i = tbl[i].t1;
      disp_rs1_val_i = tbl[i].v1;
      disp_rs2_tag_i = tbl[i].t2;
      disp_rs2_val_i = tbl[i].v2;
      set_cdb(tbl[i].ct, tbl[i].cv);
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_full, tbl[i].e_rdy, tbl[i].e_op,
              tbl[i].e1, tbl[i].e2, tbl[i].e_tt, tbl[i].e_tv);
    end

    // Younger ready entry goes first; older one issues after its wake-up
    set_disp(SRAR, ALU_1, 32'h0, NO_VAL, 32'd4);
    step(); chk_out("wake.c1", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    set_disp(SRLI, NO_VAL, 32'h8000_0000, NO_VAL, 32'd1);
    step(); chk_out("wake.c2", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    step(); chk_out("wake.c3", 1, 1, SRLI, 32'h8000_0000, 32'd1, NO_VAL, 0);
    set_cdb(ALU_1, 32'hF000_0000);
    step();
`ifdef SHIFT_RS_CDB_FWD_EN
    chk_out("wake.c4", 0, 1, SRAR, 32'hF000_0000, 32'd4, SHIFT_2, 32'h4000_0000);
    step(); chk_out("wake.c5", 0, 0, SLLI, 0, 0, SHIFT_1, 32'hFF00_0000);
    step(); chk_out("wake.c6", 0, 0, SLLI, 0, 0, NO_VAL, 0);
`else
    chk_out("wake.c4", 0, 0, SLLI, 0, 0, SHIFT_2, 32'h4000_0000);
    step(); chk_out("wake.c5", 0, 1, SRAR, 32'hF000_0000, 32'd4, NO_VAL, 0);
    step(); chk_out("wake.c6", 0, 0, SLLI, 0, 0, SHIFT_1, 32'hFF00_0000);
`endif

    // Both woken together: A (older) first, then B; dispatch while full dropped
    set_disp(SRLI, ALU_2, 32'h0, NO_VAL, 32'd1);
    step(); chk_out("age.c1", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    set_disp(SLLI, NO_VAL, 32'd3, ALU_2, 32'h0);
    step(); chk_out("age.c2", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    set_disp(SLLI, NO_VAL, 32'd7, NO_VAL, 32'd1);
    set_cdb(ALU_2, 32'h8000_0000);
    step();
`ifdef SHIFT_RS_CDB_FWD_EN
    chk_out("age.c3", 1, 1, SRLI, 32'h8000_0000, 32'd1, NO_VAL, 0);
    step(); chk_out("age.c4", 0, 1, SLLI, 32'd3, 32'h8000_0000, SHIFT_1, 32'h4000_0000);
    step(); chk_out("age.c5", 0, 0, SLLI, 0, 0, SHIFT_2, 32'd3);
    step(); chk_out("age.c6", 0, 0, SLLI, 0, 0, NO_VAL, 0);
`else
    chk_out("age.c3", 1, 0, SLLI, 0, 0, NO_VAL, 0);
    step(); chk_out("age.c4", 1, 1, SRLI, 32'h8000_0000, 32'd1, NO_VAL, 0);
    step(); chk_out("age.c5", 0, 1, SLLI, 32'd3, 32'h8000_0000, SHIFT_1, 32'h4000_0000);
    step(); chk_out("age.c6", 0, 0, SLLI, 0, 0, SHIFT_2, 32'd3);
    step(); chk_out("age.c7", 0, 0, SLLI, 0, 0, NO_VAL, 0);
`endif

    // Flush the cycle after an issue with both entries busy
    set_disp(SLLI, ALU_1, 32'd9, NO_VAL, 32'd1);
    step(); chk_out("flush.c1", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    set_disp(SLLI, NO_VAL, 32'd1, NO_VAL, 32'd2);
    step(); chk_out("flush.c2", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    set_disp(SRLI, NO_VAL, 32'd5, NO_VAL, 32'd1);
    step(); chk_out("flush.c3", 1, 1, SLLI, 32'd1, 32'd2, NO_VAL, 0);
    flush_i = 1'b1;
    set_cdb(ALU_1, 32'd2);
    step(); chk_out("flush.c4", 0, 0, SLLI, 0, 0, SHIFT_2, 32'd4);
    set_cdb(ALU_1, 32'd2);
    step(); chk_out("flush.c5", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    step(); chk_out("flush.c6", 0, 0, SLLI, 0, 0, NO_VAL, 0);

    // Reset asserted right after an issue: in-flight broadcast is discarded
    set_disp(SLLI, ALU_1, 32'd9, NO_VAL, 32'd1);
    step(); chk_out("rst.c1", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    set_disp(SLLI, NO_VAL, 32'd1, NO_VAL, 32'd2);
    step(); chk_out("rst.c2", 0, 0, SLLI, 0, 0, NO_VAL, 0);
    step(); chk_out("rst.c3", 1, 1, SLLI, 32'd1, 32'd2, NO_VAL, 0);
    reset_i = 1'b0;
    #2;
    chk("rst.async_full", 32'(full_o), 32'd0);
    chk("rst.async_ready", 32'(ready_o), 32'd0);
    chk("rst.async_term_tag", 32'(cdb_term_o.tag), 32'(NO_VAL));
    @(negedge clk_i);
    reset_i = 1'b1;
    set_cdb(ALU_1, 32'd3);
    step(); chk_out("rst.c4", 0, 0, SLLI, 0, 0, NO_VAL, 32'd4);
    set_cdb(ALU_1, 32'd3);
    step(); chk_out("rst.c5", 0, 0, SLLI, 0, 0, NO_VAL, 0);

    // Randomized traffic against an age-ordered queue model
    dtags = '{NO_VAL, NO_VAL, ALU_1, ALU_2, MUL_1};
    ctags = '{NO_VAL, ALU_1, ALU_2, MUL_1, SHIFT_1};
    for (int i = 0; i < 2; i++) m_busy[i] = 1'b0;
    m_prev_iss = 1'b0;
    m_prev_tag = NO_VAL;
    m_prev_res = '0;
    seq_cnt    = 0;
    for (int n = 0; n < 3000; n++) begin
      logic      r_flush, r_dv, e_full, e_rdy, any, pre_b0;
      shift_op_t r_op;
      rs_tag_t   r_t1, r_t2, r_ct, e_tt;
      word32_t   r_v1, r_v2, r_cv, e_tv;
      logic      el [2];
      word32_t   ov1 [2], ov2 [2];
      int        pick, idx;

      r_flush = ($urandom_range(0, 29) == 0);
      r_dv    = ($urandom_range(0, 2) != 0);
      r_op    = shift_op_t'($urandom_range(0, 3));
      r_t1    = dtags[$urandom_range(0, 4)];
      r_t2    = dtags[$urandom_range(0, 4)];
      r_ct    = ctags[$urandom_range(0, 4)];
      r_v1    = $urandom;
      r_v2    = $urandom;
      r_cv    = $urandom;

      e_full = m_busy[0] && m_busy[1];
      for (int i = 0; i < 2; i++) begin
        logic a1, a2;
        a1 = (m_q1[i] == NO_VAL) || (FWD && r_ct != NO_VAL && m_q1[i] == r_ct);
        a2 = (m_q2[i] == NO_VAL) || (FWD && r_ct != NO_VAL && m_q2[i] == r_ct);
        el[i]  = m_busy[i] && a1 && a2;
        ov1[i] = (m_q1[i] == NO_VAL) ? m_v1[i] : r_cv;
        ov2[i] = (m_q2[i] == NO_VAL) ? m_v2[i] : r_cv;
      end
      any  = el[0] || el[1];
      pick = 0;
      if (el[0] && el[1]) pick = (m_seq[0] < m_seq[1]) ? 0 : 1;
      else if (el[1])     pick = 1;
      e_rdy = any && !r_flush;
      e_tt  = m_prev_iss ? m_prev_tag : NO_VAL;
      e_tv  = m_prev_iss ? m_prev_res : 32'h0;

      flush_i = r_flush;
      if (r_dv) set_disp(r_op, r_t1, r_v1, r_t2, r_v2);
      set_cdb(r_ct, r_cv);
      step();
      chk_out($sformatf("rnd%0d", n), e_full, e_rdy, m_op[pick], ov1[pick], ov2[pick], e_tt, e_tv);

      pre_b0 = m_busy[0];
      if (r_flush) begin
        m_busy[0]  = 1'b0;
        m_busy[1]  = 1'b0;
        m_prev_iss = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_busy[i] && r_ct != NO_VAL && m_q1[i] == r_ct) begin
            m_q1[i] = NO_VAL; m_v1[i] = r_cv;
          end
          if (m_busy[i] && r_ct != NO_VAL && m_q2[i] == r_ct) begin
            m_q2[i] = NO_VAL; m_v2[i] = r_cv;
          end
        end
        m_prev_iss = e_rdy;
        m_prev_tag = (pick == 1) ? SHIFT_2 : SHIFT_1;
        m_prev_res = do_shift(m_op[pick], ov1[pick], ov2[pick]);
        if (e_rdy) m_busy[pick] = 1'b0;
        if (r_dv && !e_full) begin
          idx = pre_b0 ? 1 : 0;
          m_busy[idx] = 1'b1;
          m_seq[idx]  = seq_cnt;
          seq_cnt++;
          m_op[idx]   = r_op;
          m_q1[idx]   = (r_t1 != NO_VAL && r_t1 == r_ct) ? NO_VAL : r_t1;
          m_v1[idx]   = (r_t1 != NO_VAL && r_t1 == r_ct) ? r_cv : r_v1;
          m_q2[idx]   = (r_t2 != NO_VAL && r_t2 == r_ct) ? NO_VAL : r_t2;
          m_v2[idx]   = (r_t2 != NO_VAL && r_t2 == r_ct) ? r_cv : r_v2;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
